// File: rtl/ddr_tx_gearbox_if.sv
// Handshake and ODDR-side signal bundle for ddr_tx_gearbox.
// The master side feeds words and controls; the slave side is the gearbox itself.
interface ddr_tx_gearbox_if #(
  parameter int LANES = 4,
  parameter int BEATS = 2,
  parameter int DEPTH = 4
);
  localparam int IN_W = 2 * LANES * BEATS;
  localparam int LW   = $clog2(DEPTH) + 1;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx_oe;
  logic             clr_underrun;
  logic [LANES-1:0] oddr_d0;
  logic [LANES-1:0] oddr_d1;
  logic             oddr_tx;
  logic             busy;
  logic [LW-1:0]    fifo_level;
  logic             underrun;

  modport master (
    output in_data, in_valid, tx_oe, clr_underrun,
    input  in_ready, oddr_d0, oddr_d1, oddr_tx, busy, fifo_level, underrun
  );

  modport slave (
    input  in_data, in_valid, tx_oe, clr_underrun,
    output in_ready, oddr_d0, oddr_d1, oddr_tx, busy, fifo_level, underrun
  );
endinterface

// File: rtl/ddr_tx_gearbox.sv
// Wide-to-DDR transmit gearbox: DEPTH-word input FIFO feeding a serialiser that emits
// one LANES-wide D0/D1 pair per clk, back-to-back across words while data is queued.
module ddr_tx_gearbox #(
  parameter int               LANES     = 4,
  parameter int               BEATS     = 2,
  parameter int               DEPTH     = 4,
  parameter logic [LANES-1:0] IDLE_PAT  = '0,
  parameter bit               MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  ddr_tx_gearbox_if.slave  bus
);
  localparam int IN_W = 2 * LANES * BEATS;
  localparam int SW   = 2 * LANES;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int BW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [IN_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  state_t           state_reg;
  logic [BW-1:0]    beat_reg;
  logic [IN_W-1:0]  word_reg;
  logic [LANES-1:0] d0_reg, d1_reg;
  logic             busy_reg, underrun_reg, tx_reg;

  logic [IN_W-1:0]  head_word;
  logic [SW-1:0]    pop_slice  [BEATS];
  logic [SW-1:0]    hold_slice [BEATS];
  logic [BW-1:0]    beat_next;
  logic             push, pop, nonempty, last_beat, underrun_set;

  assign head_word    = mem[rd_ptr_reg];
  assign nonempty     = (level_reg != '0);
  assign last_beat    = (state_reg == SEND) && (beat_reg == LAST);
  assign beat_next    = beat_reg + BW'(1);
  assign bus.in_ready = !rst && (level_reg < FULL);
  assign push         = bus.in_valid && bus.in_ready;
  // A new word may start from IDLE or straight after the final beat of the current one.
  assign pop          = ((state_reg == IDLE) || last_beat) && nonempty && bus.tx_oe;
  assign underrun_set = last_beat && !nonempty && bus.tx_oe;

  // Transmission order is resolved here, so the FSM only ever walks beat index 0..BEATS-1.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
      localparam int ORD = MSB_FIRST ? (BEATS - 1 - gi) : gi;
      assign pop_slice[gi]  = head_word[ORD*SW +: SW];
      assign hold_slice[gi] = word_reg[ORD*SW +: SW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      word_reg     <= '0;
      d0_reg       <= IDLE_PAT;
      d1_reg       <= IDLE_PAT;
      busy_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      tx_reg <= ~bus.tx_oe;
      if (underrun_set)          underrun_reg <= 1'b1;
      else if (bus.clr_underrun) underrun_reg <= 1'b0;

      if (pop) begin
        state_reg        <= SEND;
        beat_reg         <= '0;
        word_reg         <= head_word;
        {d1_reg, d0_reg} <= pop_slice[0];
        busy_reg         <= 1'b1;
      end else if ((state_reg == SEND) && !last_beat) begin
        beat_reg         <= beat_next;
        {d1_reg, d0_reg} <= hold_slice[beat_next];
      end else begin
        state_reg <= IDLE;
        beat_reg  <= '0;
        d0_reg    <= IDLE_PAT;
        d1_reg    <= IDLE_PAT;
        busy_reg  <= 1'b0;
      end
    end
  end

  assign bus.oddr_d0    = d0_reg;
  assign bus.oddr_d1    = d1_reg;
  assign bus.oddr_tx    = tx_reg;
  assign bus.busy       = busy_reg;
  assign bus.fifo_level = level_reg;
  assign bus.underrun   = underrun_reg;
endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle corners,
// and random traffic against a word/beat-queue reference model.
module tb_ddr_tx_gearbox;
  localparam int L = 4, B = 2, D = 4;
  localparam logic [3:0] IP  = 4'hC;
  localparam int B2 = 4, D2 = 2;
  localparam logic [3:0] IP2 = 4'h9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_tx_gearbox_if #(.LANES(L), .BEATS(B),  .DEPTH(D))  bus_a();
  ddr_tx_gearbox_if #(.LANES(L), .BEATS(B2), .DEPTH(D2)) bus_b();

  ddr_tx_gearbox #(.LANES(L), .BEATS(B), .DEPTH(D), .IDLE_PAT(IP), .MSB_FIRST(1'b0))
    u_main (.clk(clk), .rst(rst), .bus(bus_a));
  ddr_tx_gearbox #(.LANES(L), .BEATS(B2), .DEPTH(D2), .IDLE_PAT(IP2), .MSB_FIRST(1'b1))
    u_rev (.clk(clk), .rst(rst), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO of whole words plus queue of not-yet-shown beats of the current word.
  logic [15:0] m_fifo[$];
  logic [7:0]  m_pend[$];
  logic [3:0]  m_d0, m_d1;
  logic        m_busy, m_und, m_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pend.delete();
    m_d0 = IP; m_d1 = IP;
    m_busy = 1'b0; m_und = 1'b0; m_tx = 1'b1;
  endtask

  task automatic model_edge();
    bit push, can_pop, set_u;
    logic [15:0] w;
    logic [7:0]  s;
    push    = bus_a.in_valid && (m_fifo.size() < D);
    can_pop = bus_a.tx_oe && (m_fifo.size() > 0);
    set_u   = 1'b0;
    if (m_busy && m_pend.size() > 0) begin
      s = m_pend.pop_front();
      m_d0 = s[3:0]; m_d1 = s[7:4];
    end else if (can_pop) begin
      w = m_fifo.pop_front();
      for (int k = 0; k < B; k++) m_pend.push_back(8'(w >> (8 * k)));
      s = m_pend.pop_front();
      m_d0 = s[3:0]; m_d1 = s[7:4];
      m_busy = 1'b1;
    end else begin
      if (m_busy && bus_a.tx_oe) set_u = 1'b1;
      m_busy = 1'b0;
      m_d0 = IP; m_d1 = IP;
    end
    if (set_u) m_und = 1'b1;
    else if (bus_a.clr_underrun) m_und = 1'b0;
    m_tx = !bus_a.tx_oe;
    if (push) begin
      m_fifo.push_back(bus_a.in_data);
      $display("push word=%h level=%0d", bus_a.in_data, m_fifo.size());
    end
  endtask

  task automatic check_main();
    chk("d0",    32'(bus_a.oddr_d0),    32'(m_d0));
    chk("d1",    32'(bus_a.oddr_d1),    32'(m_d1));
    chk("busy",  32'(bus_a.busy),       32'(m_busy));
    chk("tx",    32'(bus_a.oddr_tx),    32'(m_tx));
    chk("und",   32'(bus_a.underrun),   32'(m_und));
    chk("level", 32'(bus_a.fifo_level), 32'(m_fifo.size()));
    chk("ready", 32'(bus_a.in_ready),   32'(m_fifo.size() < D));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_main();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        oe;
    logic        clr;
    logic [3:0]  e0, e1;
    logic        eb, eu;
    int          el;
  } vec_t;
  vec_t tbl[16];

  initial begin
    // Two 16-bit words 0x3210,0x7654 stream as (0,1)(2,3)(4,5)(6,7); then three back-to-back words.
    tbl[0]  = '{1'b1, 16'h3210, 1'b1, 1'b0, 4'hC, 4'hC, 1'b0, 1'b0, 1};
    tbl[1]  = '{1'b1, 16'h7654, 1'b1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'h2, 4'h3, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'h4, 4'h5, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'h6, 4'h7, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'hC, 4'hC, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'hC, 4'hC, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 4'hC, 4'hC, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 16'h5678, 1'b1, 1'b0, 4'h4, 4'h3, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b1, 16'h9ABC, 1'b1, 1'b0, 4'h2, 4'h1, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'h8, 4'h7, 1'b1, 1'b0, 1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'h6, 4'h5, 1'b1, 1'b0, 1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'hC, 4'hB, 1'b1, 1'b0, 0};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'hA, 4'h9, 1'b1, 1'b0, 0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'hC, 4'hC, 1'b0, 1'b1, 0};
    tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'hC, 4'hC, 1'b0, 1'b0, 0};

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.tx_oe = 1'b0; bus_a.clr_underrun = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.tx_oe = 1'b0; bus_b.clr_underrun = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus_a.in_ready), 32'd0);
    chk("rst_tx",    32'(bus_a.oddr_tx),  32'd1);
    chk("rst_d0",    32'(bus_a.oddr_d0),  32'(IP));
    rst = 1'b0;
    #1;
    check_main();

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      bus_a.in_valid = tbl[i].v; bus_a.in_data = tbl[i].d;
      bus_a.tx_oe = tbl[i].oe;   bus_a.clr_underrun = tbl[i].clr;
      step();
      $display("vec %0d d0=%h d1=%h busy=%b und=%b level=%0d", i,
               bus_a.oddr_d0, bus_a.oddr_d1, bus_a.busy, bus_a.underrun, bus_a.fifo_level);
      chk("vec_d0",    32'(bus_a.oddr_d0),    32'(tbl[i].e0));
      chk("vec_d1",    32'(bus_a.oddr_d1),    32'(tbl[i].e1));
      chk("vec_busy",  32'(bus_a.busy),       32'(tbl[i].eb));
      chk("vec_und",   32'(bus_a.underrun),   32'(tbl[i].eu));
      chk("vec_level", 32'(bus_a.fifo_level), 32'(tbl[i].el));
    end
    bus_a.in_valid = 1'b0; bus_a.clr_underrun = 1'b0;

    // Fill FIFO with tx_oe low: 4 accepted, 5th held off
    bus_a.tx_oe = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data = 16'(16'h1357 * (k + 1));
      step();
    end
    chk("full_level", 32'(bus_a.fifo_level), 32'd4);
    chk("full_ready", 32'(bus_a.in_ready),   32'd0);
    chk("full_tx",    32'(bus_a.oddr_tx),    32'd1);
    chk("full_d0",    32'(bus_a.oddr_d0),    32'(IP));
    bus_a.tx_oe = 1'b1;
    step();
    chk("oe_tx", 32'(bus_a.oddr_tx), 32'd0);
    step();
    bus_a.in_valid = 1'b0;
    for (int c = 0; c < 30 && (bus_a.busy || bus_a.fifo_level != 0); c++) step();
    chk("drain_busy",  32'(bus_a.busy),       32'd0);
    chk("drain_level", 32'(bus_a.fifo_level), 32'd0);
    bus_a.clr_underrun = 1'b1; step(); bus_a.clr_underrun = 1'b0;

    // tx_oe drops on beat 1 of a two-word backlog
    bus_a.tx_oe = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 16'hA5C3; step();
    bus_a.in_data = 16'h5A3C; step();
    bus_a.in_valid = 1'b0;
    bus_a.tx_oe = 1'b1; step();
    bus_a.tx_oe = 1'b0; step();
    step();
    chk("oe_drop_level", 32'(bus_a.fifo_level), 32'd1);
    chk("oe_drop_und",   32'(bus_a.underrun),   32'd0);
    chk("oe_drop_busy",  32'(bus_a.busy),       32'd0);
    bus_a.tx_oe = 1'b1;
    repeat (4) step();
    bus_a.clr_underrun = 1'b1; step(); bus_a.clr_underrun = 1'b0;

    // MSB-first instance, 4 beats: 0x76543210 -> (6,7)(4,5)(2,3)(0,1)
    bus_b.tx_oe = 1'b1; bus_b.in_valid = 1'b1; bus_b.in_data = 32'h7654_3210;
    step();
    bus_b.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      $display("rev beat %0d d0=%h d1=%h", k, bus_b.oddr_d0, bus_b.oddr_d1);
      chk("rev_d0", 32'(bus_b.oddr_d0), 32'(6 - 2 * k));
      chk("rev_d1", 32'(bus_b.oddr_d1), 32'(7 - 2 * k));
      chk("rev_busy", 32'(bus_b.busy), 32'd1);
    end
    step();
    chk("rev_idle", 32'(bus_b.oddr_d0), 32'(IP2));
    chk("rev_und",  32'(bus_b.underrun), 32'd1);
    bus_b.tx_oe = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus_a.in_valid     = ($urandom % 3) != 0;
      bus_a.in_data      = 16'($urandom);
      bus_a.tx_oe        = ($urandom % 8) != 0;
      bus_a.clr_underrun = ($urandom % 16) == 0;
      step();
    end

    // Asynchronous reset mid-word
    bus_a.tx_oe = 1'b1; bus_a.clr_underrun = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 16'hBEEF; step();
    bus_a.in_data = 16'hCAFE; step();
    bus_a.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_d0",    32'(bus_a.oddr_d0),    32'(IP));
    chk("arst_d1",    32'(bus_a.oddr_d1),    32'(IP));
    chk("arst_tx",    32'(bus_a.oddr_tx),    32'd1);
    chk("arst_busy",  32'(bus_a.busy),       32'd0);
    chk("arst_level", 32'(bus_a.fifo_level), 32'd0);
    chk("arst_und",   32'(bus_a.underrun),   32'd0);
    chk("arst_ready", 32'(bus_a.in_ready),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_main();
    bus_a.in_valid = 1'b1; bus_a.in_data = 16'h0F1E; step();
    bus_a.in_valid = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
